// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches one decoded instruction per cycle and
// resolves MEM/WB operand forwarding in front of the ALU inputs.
module id_ex_stage #(
   parameter int         XLEN   = 32,
   parameter logic [4:0] NOP_OP = 5'b00000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [4:0]      id_alu_op,
   input  logic            id_b_sel,
   input  logic            id_reg_we,
   input  logic [4:0]      mem_rd,
   input  logic            mem_we,
   input  logic [XLEN-1:0] mem_result,
   input  logic [4:0]      wb_rd,
   input  logic            wb_we,
   input  logic [XLEN-1:0] wb_result,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [4:0]      ex_rd,
   output logic            ex_reg_we,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [4:0]      alu_op,
   output logic [XLEN-1:0] ex_store_data
);

   logic            valid_q;
   logic [XLEN-1:0] pc_q;
   logic [4:0]      rd_q;
   logic            reg_we_q;
   logic [4:0]      rs1_q;
   logic [4:0]      rs2_q;
   logic [XLEN-1:0] rs1_data_q;
   logic [XLEN-1:0] rs2_data_q;
   logic [XLEN-1:0] imm_q;
   logic [4:0]      alu_op_q;
   logic            b_sel_q;

   logic [XLEN-1:0] fwd_a;
   logic [XLEN-1:0] fwd_b;

   // MEM is younger than WB, so it wins when both target the same register.
   always_comb begin
      fwd_a = rs1_data_q;
      if (mem_we && mem_rd == rs1_q && rs1_q != 5'd0)
         fwd_a = mem_result;
      else if (wb_we && wb_rd == rs1_q && rs1_q != 5'd0)
         fwd_a = wb_result;

      fwd_b = rs2_data_q;
      if (mem_we && mem_rd == rs2_q && rs2_q != 5'd0)
         fwd_b = mem_result;
      else if (wb_we && wb_rd == rs2_q && rs2_q != 5'd0)
         fwd_b = wb_result;
   end

   // Flush clears the whole stage rather than just the control fields, so a
   // bubble always looks identical to the reset state.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rd_q       <= 5'd0;
         reg_we_q   <= 1'b0;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         alu_op_q   <= NOP_OP;
         b_sel_q    <= 1'b0;
      end else if (stall) begin
         // Capture forwarded operands; zeroed indices stop re-forwarding of
         // a later, unrelated writer to the same register.
         rs1_data_q <= fwd_a;
         rs2_data_q <= fwd_b;
         rs1_q      <= 5'd0;
         rs2_q      <= 5'd0;
      end else begin
         valid_q    <= id_valid;
         pc_q       <= id_pc;
         rd_q       <= id_rd;
         reg_we_q   <= id_reg_we;
         rs1_q      <= id_rs1;
         rs2_q      <= id_rs2;
         rs1_data_q <= id_rs1_data;
         rs2_data_q <= id_rs2_data;
         imm_q      <= id_imm;
         alu_op_q   <= id_alu_op;
         b_sel_q    <= id_b_sel;
      end
   end

   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_rd         = rd_q;
   assign ex_reg_we     = reg_we_q & valid_q;
   assign alu_op        = valid_q ? alu_op_q : NOP_OP;
   assign alu_a         = fwd_a;
   assign alu_b         = b_sel_q ? imm_q : fwd_b;
   assign ex_store_data = fwd_b;

endmodule
